// File: rtl/neopixel_rx_pkg.sv
// Shared constants and state encoding for the WS2812 receive-side model.
// The timing defaults are also used by the transmitter bench.
package neopixel_rx_pkg;

    // High pulse of at least this many clk cycles decodes as a 1.
    localparam int T1_MIN_CYCLES   = 10;
    // High pulse longer than this is treated as a protocol error.
    localparam int HIGH_MAX_CYCLES = 24;
    // Continuous low of this length is a latch / resync (50us at 16MHz).
    localparam int RESET_CYCLES    = 800;
    // Width of the pulse/low counters; must hold RESET_CYCLES.
    localparam int CNT_W           = 10;
    // Bits kept by one pixel before it starts forwarding.
    localparam int BITS_PER_PIXEL  = 24;
    // Width of the per-frame bit counter (holds 0..BITS_PER_PIXEL).
    localparam int BIT_CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_SYNC_WAIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_t;

endpackage

// File: rtl/neopixel_rx_if.sv
// Pixel-side signal bundle: serial data in/out plus the decoded colour
// and its status strobes. The slave side is the pixel, the master side is
// whatever drives the chain (transmitter or bench).
interface neopixel_rx_if;

    logic        din;
    logic        dout;
    logic [23:0] pixel_grb;
    logic        pixel_valid;
    logic        rx_error;

    modport master (
        output din,
        input  dout,
        input  pixel_grb,
        input  pixel_valid,
        input  rx_error
    );

    modport slave (
        input  din,
        output dout,
        output pixel_grb,
        output pixel_valid,
        output rx_error
    );

endinterface

// File: rtl/neopixel_rx_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial input. Resets to 0 so
// the line reads as idle-low while the pixel is held in reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two register stages; first may go metastable, second is used.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receive-side pixel model. Decodes the NRZ stream by measuring
// high-pulse widths, keeps the first 24 bits of a frame as its colour and
// forwards the rest of the frame on dout to the next pixel.
module neopixel_rx #(
    parameter int T1_MIN_CYCLES   = neopixel_rx_pkg::T1_MIN_CYCLES,
    parameter int HIGH_MAX_CYCLES = neopixel_rx_pkg::HIGH_MAX_CYCLES,
    parameter int RESET_CYCLES    = neopixel_rx_pkg::RESET_CYCLES,
    parameter int CNT_W           = neopixel_rx_pkg::CNT_W
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    neopixel_rx_if.slave       bus
);

    import neopixel_rx_pkg::*;

    localparam int BPP = BITS_PER_PIXEL;

    // Sized copies of the thresholds so every compare is width-matched.
    localparam logic [CNT_W-1:0]     L_T1_MIN   = CNT_W'(T1_MIN_CYCLES);
    localparam logic [CNT_W-1:0]     L_HIGH_MAX = CNT_W'(HIGH_MAX_CYCLES);
    localparam logic [CNT_W-1:0]     L_RESET    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0]     L_ONE      = CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] L_BPP      = BIT_CNT_W'(BPP);
    localparam logic [BIT_CNT_W-1:0] L_BPP_M1   = BIT_CNT_W'(BPP - 1);

    // Synchronised serial input
    logic w_din_s;

    // FSM state
    state_t r_state;
    state_t w_state_nx;

    // Datapath registers and their next values
    logic [CNT_W-1:0]     r_hi_cnt,  w_hi_cnt_nx;
    logic [CNT_W-1:0]     r_lo_cnt,  w_lo_cnt_nx;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nx;
    logic [BPP-1:0]       r_shadow,  w_shadow_nx;
    logic                 r_fwd_en,  w_fwd_en_nx;

    // Event strobes from the FSM
    logic w_latch_ok;
    logic w_err;
    logic w_bit;

    // Incremented counters, shared by several transitions
    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_lo_inc;

    // Registered outputs
    logic           r_dout;
    logic [BPP-1:0] r_pixel_grb;
    logic           r_pixel_valid;
    logic           r_rx_error;

    sync_2ff u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (bus.din),
        .o_q    (w_din_s)
    );

    assign w_hi_inc = r_hi_cnt + 1'b1;
    assign w_lo_inc = r_lo_cnt + 1'b1;
    assign w_bit    = (r_hi_cnt >= L_T1_MIN);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= ST_SYNC_WAIT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, counter updates and event strobes.
    always_comb begin
        w_state_nx   = r_state;
        w_hi_cnt_nx  = r_hi_cnt;
        w_lo_cnt_nx  = r_lo_cnt;
        w_bit_cnt_nx = r_bit_cnt;
        w_shadow_nx  = r_shadow;
        w_fwd_en_nx  = r_fwd_en;
        w_latch_ok   = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            // Only start decoding after a full-length low, so a power-up in
            // the middle of a frame cannot mis-align the bit stream.
            ST_SYNC_WAIT: begin
                if (w_din_s) begin
                    w_lo_cnt_nx = '0;
                end else if (w_lo_inc == L_RESET) begin
                    w_lo_cnt_nx = '0;
                    w_state_nx  = ST_IDLE;
                end else begin
                    w_lo_cnt_nx = w_lo_inc;
                end
            end

            ST_IDLE: begin
                if (w_din_s) begin
                    w_hi_cnt_nx = L_ONE;
                    w_state_nx  = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (w_din_s) begin
                    if (w_hi_inc > L_HIGH_MAX) begin
                        // Over-long high: abandon the frame and resync.
                        w_err        = 1'b1;
                        w_bit_cnt_nx = '0;
                        w_fwd_en_nx  = 1'b0;
                        w_lo_cnt_nx  = '0;
                        w_state_nx   = ST_SYNC_WAIT;
                    end else begin
                        w_hi_cnt_nx = w_hi_inc;
                    end
                end else begin
                    // Falling edge: the pulse width is final, decode it.
                    // Past the first 24 bits the counter saturates and the
                    // bit is only forwarded, not stored.
                    if (r_bit_cnt < L_BPP) begin
                        w_shadow_nx  = {r_shadow[BPP-2:0], w_bit};
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == L_BPP_M1) begin
                            w_fwd_en_nx = 1'b1;
                        end
                    end
                    w_lo_cnt_nx = L_ONE;
                    w_state_nx  = ST_LOW;
                end
            end

            ST_LOW: begin
                if (w_din_s) begin
                    w_hi_cnt_nx = L_ONE;
                    w_state_nx  = ST_HIGH;
                end else begin
                    if (r_lo_cnt != '1) begin
                        w_lo_cnt_nx = w_lo_inc;
                    end
                    if (w_lo_inc == L_RESET) begin
                        // Latch: a complete colour updates the pixel, a
                        // partial one is reported and dropped.
                        if (r_bit_cnt == L_BPP) begin
                            w_latch_ok = 1'b1;
                        end else if (r_bit_cnt != '0) begin
                            w_err = 1'b1;
                        end
                        w_bit_cnt_nx = '0;
                        w_fwd_en_nx  = 1'b0;
                        w_state_nx   = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nx = ST_SYNC_WAIT;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_hi_cnt      <= '0;
            r_lo_cnt      <= '0;
            r_bit_cnt     <= '0;
            r_shadow      <= '0;
            r_fwd_en      <= 1'b0;
            r_dout        <= 1'b0;
            r_pixel_grb   <= '0;
            r_pixel_valid <= 1'b0;
            r_rx_error    <= 1'b0;
        end else begin
            r_hi_cnt      <= w_hi_cnt_nx;
            r_lo_cnt      <= w_lo_cnt_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_shadow      <= w_shadow_nx;
            r_fwd_en      <= w_fwd_en_nx;
            // Forwarding uses the current enable, so the pulse that sets it
            // (bit 24) is never passed on.
            r_dout        <= w_din_s & r_fwd_en;
            r_pixel_valid <= w_latch_ok;
            r_rx_error    <= w_err;
            if (w_latch_ok) begin
                r_pixel_grb <= r_shadow;
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.pixel_grb   = r_pixel_grb;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.rx_error    = r_rx_error;

endmodule
